ccr_flag_sched: RTL and testbench
=================================

CCR_FLAG_SCHED -- requirements
Module: ccr_flag_sched

Interface
REQ-001 Parameter FLAG_W, default 4, meaning: flag vector width; bit0=Z, bit1=N, bit2=C, bit3=V.
REQ-002 Parameter RST_FLAGS, default 4'b0000, meaning: value driven on flags_o and loaded into shadow entries at reset.
REQ-003 Port clk, input, 1, meaning: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, meaning: asynchronous, active-low reset.
REQ-005 Port ccr_q, input, FLAG_W, meaning: current CCR_reg value.
REQ-006 Port alu_flag_vld, input, 1, meaning: ALU result flags valid this cycle.
REQ-007 Port alu_flags, input, FLAG_W, meaning: ALU Z/N/C/V.
REQ-008 Port alu_mask, input, FLAG_W, meaning: 1 = flag affected by current ALU op.
REQ-009 Port setc / clrc, input, 1 each, meaning: set-carry / clear-carry instruction.
REQ-010 Port int_ack, input, 1, meaning: interrupt entry; save CCR.
REQ-011 Port rti, input, 1, meaning: interrupt return; restore CCR.
REQ-012 Port stall, input, 1, meaning: pipeline stall; no new CCR write.
REQ-013 Port flags_o, output, FLAG_W, meaning: registered value for CCR Z/N/C/V inputs.
REQ-014 Port flag_en_o, output, 1, meaning: registered CCR flag_en.
REQ-015 Port busy, output, 1, meaning: high in SAVE or RESTORE.
REQ-016 Port depth, output, 2, meaning: occupied shadow entries.
REQ-017 Port ovf_err / unf_err, output, 1 each, meaning: sticky save-when-full / rti-when-empty.

Function
REQ-018 FSM states RUN, SAVE, RESTORE; reset state RUN.
REQ-019 RUN: int_ack -> SAVE; else rti with depth>0 -> RESTORE; else stay RUN; int_ack wins over simultaneous rti.
REQ-020 SAVE lasts one cycle: shadow[depth] <= ccr_q, depth+1, flag_en_o=0 next cycle; then RUN.
REQ-021 RESTORE lasts one cycle: flags_o <= shadow[depth-1], flag_en_o <= 1, depth-1; then RUN.
REQ-022 RUN, no int_ack/rti, stall=0: flags_o <= merged value, flag_en_o <= alu_flag_vld | setc | clrc.
REQ-023 Merge: base = alu_flag_vld ? (ccr_q & ~alu_mask) | (alu_flags & alu_mask) : ccr_q; then setc forces bit2=1, clrc forces bit2=0; setc&clrc together leave bit2 of base unchanged.
REQ-024 Latency: request cycle N -> flag_en_o high cycle N+1 -> CCR updated at edge ending N+1.
REQ-025 stall=1 in RUN: flag_en_o <= 0, flags_o held; int_ack/rti still honoured.
REQ-026 ALU/setc/clrc requests arriving while busy=1 are dropped (caller holds them via stall).
REQ-027 int_ack with depth at capacity: no save, depth unchanged, stays RUN, ovf_err set.
REQ-028 rti with depth=0: stays RUN, no write, unf_err set.
REQ-029 flag_en_o is never high on two consecutive cycles originating from one request.

Reset
REQ-030 rst low: state RUN, flags_o=RST_FLAGS, flag_en_o=0, busy=0, depth=0, ovf_err=0, unf_err=0, shadow entries=RST_FLAGS, immediately and asynchronously.
REQ-031 Reset mid-SAVE or mid-RESTORE abandons the operation; first post-reset cycle is RUN.
REQ-032 Error flags clear only by reset.

Configuration
REQ-033 Macro CCR_NEST_EN defined: shadow capacity 2 (one nested interrupt), depth range 0..2.
REQ-034 CCR_NEST_EN undefined: capacity 1, depth range 0..1, second int_ack before rti raises ovf_err.

Structure
REQ-035 Shared package ccr_pkg holds flag bit indices (Z_BIT=0, N_BIT=1, C_BIT=2, V_BIT=3), FSM state enum, shadow capacity constants.
REQ-036 One sub-module ccr_shadow_stack (push/pop LIFO, depth, full/empty); merge logic and FSM stay in top.

Verification
REQ-037 Reset, then alu_flag_vld=1, alu_flags=1111, mask=1111 -> next cycle flags_o=1111, flag_en_o=1.
REQ-038 ccr_q=0101, alu_flags=0010, mask=0011 -> flags_o=0110; add setc -> 0110, clrc -> 0010, setc+clrc -> 0110.
REQ-039 ccr_q=1001, int_ack -> busy 1 cycle, depth=1, flag_en_o=0; later ccr_q=0000, rti -> flags_o=1001, flag_en_o=1, depth=0.
REQ-040 With CCR_NEST_EN: two int_ack saving 0001 then 0100, two rti -> restores 0100 then 0001; without: second int_ack -> ovf_err=1.
REQ-041 rti with depth=0 -> unf_err=1, flag_en_o=0; stall=1 with alu_flag_vld=1 -> flag_en_o=0.
REQ-042 rst asserted during SAVE -> all outputs reset values same cycle, depth=0.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared constants and types for the CCR flag scheduler.
// Holds flag bit positions, the scheduler FSM state type and the shadow
// stack capacity. Define CCR_NEST_EN to allow one nested interrupt
// (capacity 2); otherwise a single shadow entry is provided.
package ccr_pkg;

    localparam int unsigned Z_BIT = 0;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned C_BIT = 2;
    localparam int unsigned V_BIT = 3;

    // Width of the occupancy counter; covers 0..2.
    localparam int unsigned DEPTH_W = 2;

`ifdef CCR_NEST_EN
    localparam int unsigned SHADOW_CAP = 2;
`else
    localparam int unsigned SHADOW_CAP = 1;
`endif

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved CCR values used across interrupt entry/return.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   push, din  - store din on top (ignored when full)
//   pop        - discard top entry (ignored when empty)
//   top        - current top entry (RST_FLAGS when empty)
//   depth      - number of occupied entries
//   full/empty - occupancy status
module ccr_shadow_stack
    import ccr_pkg::*;
#(
    parameter int unsigned       FLAG_W    = 4,
    parameter logic [FLAG_W-1:0] RST_FLAGS = '0,
    parameter int unsigned       CAP       = SHADOW_CAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [FLAG_W-1:0]  din,
    output logic [FLAG_W-1:0]  top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [FLAG_W-1:0] mem [CAP];

    assign full  = (depth == DEPTH_W'(CAP));
    assign empty = (depth == '0);

    // Entry storage and occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= '0;
            for (int unsigned i = 0; i < CAP; i++) begin
                mem[i] <= RST_FLAGS;
            end
        end else if (push && !full) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                if (32'(depth) == i) begin
                    mem[i] <= din;
                end
            end
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Top-of-stack select; a loop avoids a zero-width index at capacity 1.
    always_comb begin
        top = RST_FLAGS;
        for (int unsigned i = 0; i < CAP; i++) begin
            if (32'(depth) == i + 32'd1) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/ccr_flag_sched.sv
// CCR flag scheduler: merges ALU / set-carry / clear-carry updates into the
// condition code register and saves/restores it around interrupts.
// Optional feature: define CCR_NEST_EN for a two-deep shadow stack.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   ccr_q         - current CCR contents
//   alu_flag_vld  - ALU flags valid; alu_flags/alu_mask select affected bits
//   setc, clrc    - force carry to 1 / 0 (both together: no carry change)
//   int_ack, rti  - interrupt entry (save) / return (restore)
//   stall         - suppress new CCR writes while in RUN
//   flags_o       - registered next CCR value
//   flag_en_o     - registered CCR write enable
//   busy          - save or restore in progress
//   depth         - occupied shadow entries
//   ovf_err       - sticky: int_ack with stack full
//   unf_err       - sticky: rti with stack empty
module ccr_flag_sched
    import ccr_pkg::*;
#(
    parameter int unsigned       FLAG_W    = 4,
    parameter logic [FLAG_W-1:0] RST_FLAGS = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLAG_W-1:0]  ccr_q,
    input  logic               alu_flag_vld,
    input  logic [FLAG_W-1:0]  alu_flags,
    input  logic [FLAG_W-1:0]  alu_mask,
    input  logic               setc,
    input  logic               clrc,
    input  logic               int_ack,
    input  logic               rti,
    input  logic               stall,
    output logic [FLAG_W-1:0]  flags_o,
    output logic               flag_en_o,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf_err,
    output logic               unf_err
);

    localparam logic [FLAG_W-1:0] C_MASK = FLAG_W'(1) << C_BIT;

    state_t            state;
    state_t            state_nxt;
    logic [FLAG_W-1:0] merged;
    logic [FLAG_W-1:0] flags_nxt;
    logic              flag_en_nxt;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;
    logic [FLAG_W-1:0] shadow_top;
    logic              shadow_full;
    logic              shadow_empty;

    ccr_shadow_stack #(
        .FLAG_W    (FLAG_W),
        .RST_FLAGS (RST_FLAGS),
        .CAP       (SHADOW_CAP)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ccr_q),
        .top   (shadow_top),
        .depth (depth),
        .full  (shadow_full),
        .empty (shadow_empty)
    );

    // ALU merge followed by carry override; setc with clrc cancels out.
    always_comb begin
        merged = alu_flag_vld ? ((ccr_q & ~alu_mask) | (alu_flags & alu_mask)) : ccr_q;
        if (setc && !clrc) begin
            merged = merged | C_MASK;
        end else if (clrc && !setc) begin
            merged = merged & ~C_MASK;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        flags_nxt   = flags_o;
        flag_en_nxt = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        case (state)
            RUN: begin
                if (int_ack) begin
                    if (shadow_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        state_nxt = SAVE;
                    end
                end else if (rti) begin
                    if (shadow_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        state_nxt = RESTORE;
                    end
                end else if (!stall) begin
                    flags_nxt   = merged;
                    flag_en_nxt = alu_flag_vld | setc | clrc;
                end
            end
            SAVE: begin
                push      = 1'b1;
                state_nxt = RUN;
            end
            RESTORE: begin
                // Restore completes regardless of stall so the saved CCR is never lost.
                pop         = 1'b1;
                flags_nxt   = shadow_top;
                flag_en_nxt = 1'b1;
                state_nxt   = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flags_o   <= RST_FLAGS;
            flag_en_o <= 1'b0;
            busy      <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            flags_o   <= flags_nxt;
            flag_en_o <= flag_en_nxt;
            busy      <= (state_nxt != RUN);
            ovf_err   <= ovf_err | ovf_set;
            unf_err   <= unf_err | unf_set;
        end
    end

endmodule

// File: tb/tb_ccr_flag_sched.sv
// Testbench for ccr_flag_sched: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_ccr_flag_sched;

`ifdef CCR_NEST_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [3:0] ccr;
        logic [3:0] alu;
        logic [3:0] mask;
        logic       vld;
        logic       setc;
        logic       clrc;
        logic       ia;
        logic       rti;
        logic       stall;
    } stim_t;

    typedef struct packed {
        logic [3:0] flags;
        logic       en;
        logic       busy;
        logic [1:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ccr_q, alu_flags, alu_mask;
    logic       alu_flag_vld, setc, clrc, int_ack, rti, stall;
    logic [3:0] flags_o;
    logic       flag_en_o, busy, ovf_err, unf_err;
    logic [1:0] depth;

    int checks = 0;
    int errors = 0;

    // Reference model state: saved CCR values, pending operation, sticky errors.
    logic [3:0] sh[$];
    int         pending;   // 0 none, 1 save next edge, 2 restore next edge
    logic [3:0] m_flags;
    logic       m_en, m_ovf, m_unf;
    exp_t       expq[$];
    logic [3:0] last_ccr;

    ccr_flag_sched dut (
        .clk          (clk),
        .rst          (rst),
        .ccr_q        (ccr_q),
        .alu_flag_vld (alu_flag_vld),
        .alu_flags    (alu_flags),
        .alu_mask     (alu_mask),
        .setc         (setc),
        .clrc         (clrc),
        .int_ack      (int_ack),
        .rti          (rti),
        .stall        (stall),
        .flags_o      (flags_o),
        .flag_en_o    (flag_en_o),
        .busy         (busy),
        .depth        (depth),
        .ovf_err      (ovf_err),
        .unf_err      (unf_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, x, $time);
        end
    endfunction

    function automatic stim_t mk(logic [3:0] c, logic [3:0] a, logic [3:0] m,
                                 logic v, logic sc, logic cc, logic ia,
                                 logic rt, logic st);
        stim_t s;
        s.ccr = c; s.alu = a; s.mask = m; s.vld = v; s.setc = sc;
        s.clrc = cc; s.ia = ia; s.rti = rt; s.stall = st;
        return s;
    endfunction

    // Bitwise merge: each flag comes from the ALU if valid and masked, else CCR.
    function automatic logic [3:0] merge(stim_t s);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b] = (s.vld && s.mask[b]) ? s.alu[b] : s.ccr[b];
        end
        if (s.setc != s.clrc) r[2] = s.setc;
        return r;
    endfunction

    task automatic model_reset();
        sh.delete();
        pending = 0;
        m_flags = 4'b0000;
        m_en    = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        expq.delete();
    endtask

    // Predict the outputs after the coming rising edge.
    task automatic model_apply(stim_t s);
        exp_t e;
        if (pending == 1) begin
            sh.push_back(s.ccr);
            m_en = 1'b0;
            pending = 0;
        end else if (pending == 2) begin
            m_flags = sh.pop_back();
            m_en = 1'b1;
            pending = 0;
        end else if (s.ia) begin
            m_en = 1'b0;
            if (sh.size() == CAP) m_ovf = 1'b1;
            else pending = 1;
        end else if (s.rti) begin
            m_en = 1'b0;
            if (sh.size() == 0) m_unf = 1'b1;
            else pending = 2;
        end else if (s.stall) begin
            m_en = 1'b0;
        end else begin
            m_flags = merge(s);
            m_en = s.vld | s.setc | s.clrc;
        end
        e.flags = m_flags;
        e.en    = m_en;
        e.busy  = (pending != 0);
        e.depth = 2'(sh.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        expq.push_back(e);
    endtask

    task automatic drive_and_model(stim_t s);
        ccr_q = s.ccr; alu_flags = s.alu; alu_mask = s.mask;
        alu_flag_vld = s.vld; setc = s.setc; clrc = s.clrc;
        int_ack = s.ia; rti = s.rti; stall = s.stall;
        last_ccr = s.ccr;
        model_apply(s);
    endtask

    task automatic step(stim_t s);
        @(negedge clk);
        drive_and_model(s);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_flags", 32'(flags_o), 32'h0);
        chk("rst_en", 32'(flag_en_o), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_ovf", 32'(ovf_err), 32'h0);
        chk("rst_unf", 32'(unf_err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive_and_model(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    endtask

    // Monitor: every cycle out of reset, compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && expq.size() > 0) begin
                e = expq.pop_front();
                chk("flags_o", 32'(flags_o), 32'(e.flags));
                chk("flag_en_o", 32'(flag_en_o), 32'(e.en));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("depth", 32'(depth), 32'(e.depth));
                chk("ovf_err", 32'(ovf_err), 32'(e.ovf));
                chk("unf_err", 32'(unf_err), 32'(e.unf));
            end
        end
    end

    initial begin
        stim_t idle;
        stim_t s;
        idle = mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        ccr_q = '0; alu_flags = '0; alu_mask = '0;
        alu_flag_vld = 0; setc = 0; clrc = 0; int_ack = 0; rti = 0; stall = 0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_flags", 32'(flags_o), 32'h0);
        do_reset();

        // Full ALU write.
        step(mk(4'h0, 4'hf, 4'hf, 1, 0, 0, 0, 0, 0)); after_edge();
        chk("alu_all_flags", 32'(flags_o), 32'hf);
        chk("alu_all_en", 32'(flag_en_o), 32'h1);

        // Partial mask and carry overrides.
        step(mk(4'h5, 4'h2, 4'h3, 1, 0, 0, 0, 0, 0)); after_edge();
        chk("merge", 32'(flags_o), 32'h6);
        step(mk(4'h5, 4'h2, 4'h3, 1, 1, 0, 0, 0, 0)); after_edge();
        chk("merge_setc", 32'(flags_o), 32'h6);
        step(mk(4'h5, 4'h2, 4'h3, 1, 0, 1, 0, 0, 0)); after_edge();
        chk("merge_clrc", 32'(flags_o), 32'h2);
        step(mk(4'h5, 4'h2, 4'h3, 1, 1, 1, 0, 0, 0)); after_edge();
        chk("merge_both", 32'(flags_o), 32'h6);

        // Save then restore.
        step(mk(4'h9, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0)); after_edge();
        chk("save_busy", 32'(busy), 32'h1);
        chk("save_en", 32'(flag_en_o), 32'h0);
        step(mk(4'h9, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); after_edge();
        chk("save_done_busy", 32'(busy), 32'h0);
        chk("save_depth", 32'(depth), 32'h1);
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0)); after_edge();
        chk("restore_busy", 32'(busy), 32'h1);
        step(idle); after_edge();
        chk("restore_flags", 32'(flags_o), 32'h9);
        chk("restore_en", 32'(flag_en_o), 32'h1);
        chk("restore_depth", 32'(depth), 32'h0);

        // Nesting or overflow.
        step(mk(4'h1, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0));
        step(mk(4'h1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
        step(mk(4'h4, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0));
        step(mk(4'h4, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); after_edge();
`ifdef CCR_NEST_EN
        chk("nest_depth", 32'(depth), 32'h2);
        chk("nest_ovf", 32'(ovf_err), 32'h0);
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0));
        step(idle); after_edge();
        chk("nest_restore1", 32'(flags_o), 32'h4);
`else
        chk("ovf_err", 32'(ovf_err), 32'h1);
        chk("ovf_depth", 32'(depth), 32'h1);
`endif
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0));
        step(idle); after_edge();
        chk("nest_restore2", 32'(flags_o), 32'h1);
        chk("nest_empty", 32'(depth), 32'h0);

        // Underflow and stall.
        step(mk(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0)); after_edge();
        chk("unf_err", 32'(unf_err), 32'h1);
        chk("unf_en", 32'(flag_en_o), 32'h0);
        step(mk(4'h3, 4'hc, 4'hf, 1, 0, 0, 0, 0, 1)); after_edge();
        chk("stall_en", 32'(flag_en_o), 32'h0);
        chk("stall_hold", 32'(flags_o), 32'h1);

        // Random traffic; interrupt controls only while idle, ccr held into SAVE.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s.ccr   = 4'($urandom);
            s.alu   = 4'($urandom);
            s.mask  = 4'($urandom);
            s.vld   = 1'($urandom_range(0, 1));
            s.setc  = ($urandom_range(0, 3) == 0);
            s.clrc  = ($urandom_range(0, 3) == 0);
            s.stall = ($urandom_range(0, 4) == 0);
            s.ia    = (pending == 0) && ($urandom_range(0, 7) == 0);
            s.rti   = (pending == 0) && ($urandom_range(0, 6) == 0);
            if (pending == 1) s.ccr = last_ccr;
            step(s);
        end

        // Reset in the middle of a save.
        do_reset();
        step(mk(4'h0, 4'hf, 4'hf, 1, 0, 0, 0, 0, 0));
        step(mk(4'ha, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0)); after_edge();
        chk("midsave_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("midsave_rst_flags", 32'(flags_o), 32'h0);
        chk("midsave_rst_en", 32'(flag_en_o), 32'h0);
        chk("midsave_rst_busy", 32'(busy), 32'h0);
        chk("midsave_rst_depth", 32'(depth), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_and_model(mk(4'ha, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
        after_edge();
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_depth", 32'(depth), 32'h0);

        step(idle); after_edge();
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
